ssd_mux_ctrl: RTL and testbench

- Parametrised multi-digit seven-segment display controller for the board I/O layer.
- Latches a 4-bit switch value into a digit slot selected by a debounced pushbutton.
- Time-multiplexes NUM_DIGITS common-anode digits and mirrors the switch value on the LEDs.
- Extends the existing single-board display path with:
  - button debounce and edge detect
  - configurable digit count and refresh rate
  - optional hex decode
  - blanking
  - synchronous reset

---
 rtl/ssd_mux_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ssd_mux_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_mux_ctrl.sv
// Multi-digit common-anode seven-segment controller: debounced per-slot load buttons,
// time-multiplexed scan with blanking, optional hex decode and a switch mirror on the LEDs.
module ssd_mux_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_PERIOD = 65536,
    parameter int DBNC_CYCLES  = 250000,
    parameter int HEX_MODE     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            value,
    input  logic [NUM_DIGITS-1:0] load_btn,
    input  logic                  blank_all,
    output logic [3:0]            led,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  load_done
);

    localparam int PW = $clog2(DIGIT_PERIOD);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(DBNC_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIGIT_PERIOD - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] DBNC_LAST  = CW'(DBNC_CYCLES - 1);

    logic [NUM_DIGITS-1:0] strobe;
    logic [3:0]            slot_code_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] slot_valid_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_btn
            logic          sync1_q, sync2_q, lvl_q;
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    lvl_q   <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= load_btn[gi];
                    sync2_q <= sync1_q;
                    if (sync2_q != lvl_q) begin
                        if (cnt_q == DBNC_LAST) begin
                            lvl_q <= sync2_q;
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
            end

            // Strobe fires in the cycle the debounced level is about to rise.
            assign strobe[gi] = sync2_q & ~lvl_q & (cnt_q == DBNC_LAST);

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_code_q[gi]  <= 4'd0;
                    slot_valid_q[gi] <= 1'b0;
                end else if (strobe[gi]) begin
                    slot_code_q[gi]  <= value;
                    slot_valid_q[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            4'd10:   s = 7'b0001000;
            4'd11:   s = 7'b0000011;
            4'd12:   s = 7'b1000110;
            4'd13:   s = 7'b0100001;
            4'd14:   s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        if (HEX_MODE == 0 && code > 4'd9) begin
            s = 7'h7F;
        end
        return s;
    endfunction

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic [3:0]            led_q, led_d;
    logic                  load_done_q;
    logic [3:0]            cur_code;
    logic                  cur_valid;

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        cur_code  = 4'd0;
        cur_valid = 1'b0;
        an_d      = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_code  = slot_code_q[i];
                cur_valid = slot_valid_q[i];
                an_d[NUM_DIGITS-1-i] = 1'b0;
            end
        end
        seg_d = cur_valid ? decode(cur_code) : 7'h7F;
        if (blank_all) begin
            an_d  = '1;
            seg_d = 7'h7F;
        end
        led_d = (HEX_MODE != 0 || value <= 4'd9) ? value : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            led_q       <= 4'd0;
            load_done_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            led_q       <= led_d;
            load_done_q <= |strobe;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign led       = led_q;
    assign load_done = load_done_q;

endmodule

// File: tb/tb_ssd_mux_ctrl.sv
// Scoreboard bench for ssd_mux_ctrl: three instances (4-digit decimal, 4-digit hex,
// 8-digit hex with fast scan) checked every cycle against a cycle-count based model.
module tb_ssd_mux_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] value;
    logic [3:0] load_btn;
    logic       blank_all;

    logic [3:0] led0, led1, led2;
    logic [6:0] seg0, seg1, seg2;
    logic [3:0] an0, an1;
    logic [7:0] an2;
    logic       done0, done1, done2;

    always #5 clk = ~clk;

    ssd_mux_ctrl #(.NUM_DIGITS(4), .DIGIT_PERIOD(4), .DBNC_CYCLES(4), .HEX_MODE(0)) u_dut (
        .clk(clk), .rst(rst), .value(value), .load_btn(load_btn), .blank_all(blank_all),
        .led(led0), .seg(seg0), .an(an0), .load_done(done0));

    ssd_mux_ctrl #(.NUM_DIGITS(4), .DIGIT_PERIOD(4), .DBNC_CYCLES(4), .HEX_MODE(1)) u_hex (
        .clk(clk), .rst(rst), .value(value), .load_btn(load_btn), .blank_all(blank_all),
        .led(led1), .seg(seg1), .an(an1), .load_done(done1));

    ssd_mux_ctrl #(.NUM_DIGITS(8), .DIGIT_PERIOD(2), .DBNC_CYCLES(4), .HEX_MODE(1)) u_n8 (
        .clk(clk), .rst(rst), .value(value), .load_btn({4'b0000, load_btn}), .blank_all(blank_all),
        .led(led2), .seg(seg2), .an(an2), .load_done(done2));

    typedef struct {
        int         k;
        logic [7:0] an;
        logic [6:0] seg;
        logic [3:0] led;
        logic       done;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    // Model state per instance
    int         nv [3] = '{4, 4, 8};
    int         dpv[3] = '{4, 4, 2};
    int         hxv[3] = '{0, 1, 1};
    localparam int DB = 4;
    logic       m_s1  [3][8];
    logic       m_s2  [3][8];
    logic       m_lvl [3][8];
    int         m_cnt [3][8];
    logic [3:0] m_code[3][8];
    logic       m_val [3][8];
    int         m_cyc [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] c, input int hx);
        case (c)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: ;
        endcase
        if (hx == 0) return 7'h7F;
        case (c)
            4'd10:   return 7'b0001000;
            4'd11:   return 7'b0000011;
            4'd12:   return 7'b1000110;
            4'd13:   return 7'b0100001;
            4'd14:   return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Predict what every instance shows after the coming edge, then compare.
    task automatic tick();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            int   n = nv[k];
            int   idx;
            logic any = 1'b0;
            logic stb [8];
            e.k    = k;
            e.an   = 8'hFF >> (8 - n);
            e.seg  = 7'h7F;
            e.led  = 4'd0;
            e.done = 1'b0;
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    m_s1[k][i] = 0; m_s2[k][i] = 0; m_lvl[k][i] = 0;
                    m_cnt[k][i] = 0; m_code[k][i] = 0; m_val[k][i] = 0;
                end
                m_cyc[k] = 0;
            end else begin
                idx = (m_cyc[k] / dpv[k]) % n;
                if (!blank_all) begin
                    e.an[n-1-idx] = 1'b0;
                    if (m_val[k][idx]) e.seg = ref_seg(m_code[k][idx], hxv[k]);
                end
                e.led = (value < 10 || hxv[k] != 0) ? value : 4'd0;
                for (int i = 0; i < n; i++) begin
                    stb[i] = 1'b0;
                    if (m_s2[k][i] != m_lvl[k][i]) begin
                        m_cnt[k][i]++;
                        if (m_cnt[k][i] == DB) begin
                            m_lvl[k][i] = m_s2[k][i];
                            m_cnt[k][i] = 0;
                            stb[i] = m_lvl[k][i];
                        end
                    end else begin
                        m_cnt[k][i] = 0;
                    end
                    m_s2[k][i] = m_s1[k][i];
                    m_s1[k][i] = (i < 4) ? load_btn[i] : 1'b0;
                    if (stb[i]) begin
                        m_code[k][i] = value;
                        m_val[k][i]  = 1'b1;
                        any = 1'b1;
                    end
                end
                e.done = any;
                m_cyc[k]++;
            end
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.k)
                0: begin
                    check("an0", {4'b0, an0}, e.an);   check("seg0", seg0, e.seg);
                    check("led0", led0, e.led);        check("done0", done0, e.done);
                end
                1: begin
                    check("an1", {4'b0, an1}, e.an);   check("seg1", seg1, e.seg);
                    check("led1", led1, e.led);        check("done1", done1, e.done);
                end
                default: begin
                    check("an2", an2, e.an);           check("seg2", seg2, e.seg);
                    check("led2", led2, e.led);        check("done2", done2, e.done);
                end
            endcase
        end
        if (done0) done_cnt++;
        $display("cyc t=%0t rst=%0b val=%0d btn=%b blank=%0b | an0=%b seg0=%b led0=%0d done0=%0b an2=%b",
                 $time, rst, value, load_btn, blank_all, an0, seg0, led0, done0, an2);
    endtask

    task automatic press(input logic [3:0] mask, input logic [3:0] v, input int hold);
        value    = v;
        load_btn = mask;
        repeat (hold) tick();
        load_btn = 4'b0;
        repeat (8) tick();
    endtask

    initial begin
        rst = 1'b1; value = 4'd0; load_btn = 4'b0; blank_all = 1'b0;
        repeat (2) tick();
        check("reset_an", {28'b0, an0}, 32'hF);
        check("reset_seg", {25'b0, seg0}, 32'h7F);
        rst = 1'b0;
        repeat (16) tick();

        done_cnt = 0;
        press(4'b0001, 4'd7, 3);
        check("short_pulse_no_load", done_cnt, 0);
        done_cnt = 0;
        press(4'b0001, 4'd7, 20);
        check("held_one_load", done_cnt, 1);
        repeat (8) tick();

        press(4'b0001, 4'd1, 6);
        press(4'b0010, 4'd2, 6);
        press(4'b0100, 4'd3, 6);
        press(4'b1000, 4'd4, 6);
        repeat (40) tick();

        press(4'b0100, 4'd11, 6);
        check("led_hex0", {28'b0, led0}, 32'd0);
        check("led_hex1", {28'b0, led1}, 32'd11);
        repeat (20) tick();

        done_cnt = 0;
        press(4'b1010, 4'd5, 6);
        check("simul_one_done", done_cnt, 1);
        repeat (16) tick();

        blank_all = 1'b1;
        repeat (10) tick();
        blank_all = 1'b0;
        repeat (20) tick();

        rst = 1'b1;
        tick();
        check("midrst_an", {28'b0, an0}, 32'hF);
        check("midrst_seg", {25'b0, seg0}, 32'h7F);
        check("midrst_led", {28'b0, led0}, 32'd0);
        rst = 1'b0;
        repeat (20) tick();

        for (int r = 0; r < 60; r++) begin
            blank_all = ($urandom_range(0, 5) == 0);
            press(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), $urandom_range(1, 8));
        end
        blank_all = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
